axi4_lite_xbar_1xn: RTL and testbench

Parametrised 1-to-N AXI4-Lite interconnect between the CPU-side AXI4-Lite master and SLAVE_NUM peripheral slaves. It generalises the fixed two-slave peripheral fabric to any slave count and region size. Write and read paths run independently, one outstanding transaction each, and unmapped addresses receive DECERR. A saturating error counter is exposed for debug.

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_decoder.sv | 23 ++
 rtl/axi4_lite_xbar_1xn.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi4_lite_xbar_1xn.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared constants, FSM state types and sizing helper for the AXI4-Lite 1xN crossbar.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_OUT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_OUT} r_state_t;

    // Slave-select width; a single slave still gets a 1-bit index.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/axi4_lite_decoder.sv
// Address decoder: region index from the bits above REGION_BITS, flags unmapped addresses.
module axi4_lite_decoder
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SLAVE_NUM   = 2,
    parameter int unsigned REGION_BITS = 8,
    localparam int unsigned SEL_W      = sel_width(SLAVE_NUM)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [SEL_W-1:0]      sel,
    output logic                  unmapped
);

    localparam int unsigned TOP_LSB = REGION_BITS + SEL_W;

    logic [ADDR_WIDTH-1:0] upper;

    assign upper    = addr >> TOP_LSB;
    assign sel      = SEL_W'(addr >> REGION_BITS);
    assign unmapped = (upper != '0) || (32'(sel) >= SLAVE_NUM);

endmodule

// File: rtl/axi4_lite_xbar_1xn.sv
// 1-to-N AXI4-Lite interconnect: independent single-outstanding write and read paths,
// DECERR for unmapped addresses, saturating DECERR counter for debug.
module axi4_lite_xbar_1xn
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SLAVE_NUM   = 2,
    parameter int unsigned REGION_BITS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDR_WIDTH-1:0]                 s_awaddr,
    input  logic                                  s_awvalid,
    output logic                                  s_awready,
    input  logic [DATA_WIDTH-1:0]                 s_wdata,
    input  logic [DATA_WIDTH/8-1:0]               s_wstrb,
    input  logic                                  s_wvalid,
    output logic                                  s_wready,
    output logic [1:0]                            s_bresp,
    output logic                                  s_bvalid,
    input  logic                                  s_bready,
    input  logic [ADDR_WIDTH-1:0]                 s_araddr,
    input  logic                                  s_arvalid,
    output logic                                  s_arready,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  s_rvalid,
    input  logic                                  s_rready,
    output logic [SLAVE_NUM*ADDR_WIDTH-1:0]       m_awaddr,
    output logic [SLAVE_NUM*DATA_WIDTH-1:0]       m_wdata,
    output logic [SLAVE_NUM*(DATA_WIDTH/8)-1:0]   m_wstrb,
    output logic [SLAVE_NUM*ADDR_WIDTH-1:0]       m_araddr,
    output logic [SLAVE_NUM-1:0]                  m_awvalid,
    output logic [SLAVE_NUM-1:0]                  m_wvalid,
    output logic [SLAVE_NUM-1:0]                  m_bready,
    output logic [SLAVE_NUM-1:0]                  m_arvalid,
    output logic [SLAVE_NUM-1:0]                  m_rready,
    input  logic [SLAVE_NUM-1:0]                  m_awready,
    input  logic [SLAVE_NUM-1:0]                  m_wready,
    input  logic [SLAVE_NUM-1:0]                  m_bvalid,
    input  logic [SLAVE_NUM-1:0]                  m_arready,
    input  logic [SLAVE_NUM-1:0]                  m_rvalid,
    input  logic [SLAVE_NUM*2-1:0]                m_bresp,
    input  logic [SLAVE_NUM*2-1:0]                m_rresp,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0]       m_rdata,
    output logic [15:0]                           err_count
);

    localparam int unsigned SEL_W  = sel_width(SLAVE_NUM);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    w_state_t              w_state, w_state_n;
    r_state_t              r_state, r_state_n;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data, r_data;
    logic [STRB_W-1:0]     w_strb;
    logic [SEL_W-1:0]      w_sel, r_sel, aw_dec_sel, ar_dec_sel;
    logic                  aw_dec_unmapped, ar_dec_unmapped;
    logic                  aw_done, w_done;
    logic [1:0]            b_resp, r_resp;
    logic [SLAVE_NUM-1:0]  w_oh, r_oh;
    logic                  w_accept, aw_hs, wd_hs, b_hs;
    logic                  r_accept, ar_hs, rd_hs;
    logic [1:0]            m_bresp_sel, m_rresp_sel;
    logic [DATA_WIDTH-1:0] m_rdata_sel;
    logic [1:0]            err_inc;
    logic [16:0]           err_sum;

    axi4_lite_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLAVE_NUM  (SLAVE_NUM),
        .REGION_BITS(REGION_BITS)
    ) u_aw_dec (
        .addr    (s_awaddr),
        .sel     (aw_dec_sel),
        .unmapped(aw_dec_unmapped)
    );

    axi4_lite_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLAVE_NUM  (SLAVE_NUM),
        .REGION_BITS(REGION_BITS)
    ) u_ar_dec (
        .addr    (s_araddr),
        .sel     (ar_dec_sel),
        .unmapped(ar_dec_unmapped)
    );

    assign w_oh = SLAVE_NUM'(1) << w_sel;
    assign r_oh = SLAVE_NUM'(1) << r_sel;

    // Captured request is broadcast; only the selected slave sees a valid.
    assign m_awaddr = {SLAVE_NUM{aw_addr}};
    assign m_wdata  = {SLAVE_NUM{w_data}};
    assign m_wstrb  = {SLAVE_NUM{w_strb}};
    assign m_araddr = {SLAVE_NUM{ar_addr}};
    assign s_bresp  = b_resp;
    assign s_rresp  = r_resp;
    assign s_rdata  = r_data;

    always_comb begin
        m_bresp_sel = '0;
        m_rresp_sel = '0;
        m_rdata_sel = '0;
        for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            if (w_sel == SEL_W'(i)) m_bresp_sel = m_bresp[2*i +: 2];
            if (r_sel == SEL_W'(i)) begin
                m_rresp_sel = m_rresp[2*i +: 2];
                m_rdata_sel = m_rdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Write path next-state and state-decoded handshake outputs.
    always_comb begin
        w_state_n = w_state;
        w_accept  = 1'b0;
        aw_hs     = 1'b0;
        wd_hs     = 1'b0;
        b_hs      = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        unique case (w_state)
            W_IDLE: begin
                s_awready = s_awvalid & s_wvalid;
                s_wready  = s_awvalid & s_wvalid;
                if (s_awvalid && s_wvalid) begin
                    w_accept  = 1'b1;
                    w_state_n = aw_dec_unmapped ? W_OUT : W_FWD;
                end
            end
            W_FWD: begin
                m_awvalid = aw_done ? '0 : w_oh;
                m_wvalid  = w_done ? '0 : w_oh;
                aw_hs     = !aw_done && (|(m_awready & w_oh));
                wd_hs     = !w_done && (|(m_wready & w_oh));
                if ((aw_done || aw_hs) && (w_done || wd_hs)) w_state_n = W_RESP;
            end
            W_RESP: begin
                m_bready = w_oh;
                b_hs     = |(m_bvalid & w_oh);
                if (b_hs) w_state_n = W_OUT;
            end
            W_OUT: begin
                s_bvalid = 1'b1;
                if (s_bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_sel   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            b_resp  <= OKAY;
        end else begin
            w_state <= w_state_n;
            if (w_accept) begin
                aw_addr <= s_awaddr;
                w_data  <= s_wdata;
                w_strb  <= s_wstrb;
                w_sel   <= aw_dec_sel;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (aw_dec_unmapped) b_resp <= DECERR;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (wd_hs) w_done <= 1'b1;
            if (b_hs)  b_resp <= m_bresp_sel;
        end
    end

    // Read path next-state and state-decoded handshake outputs.
    always_comb begin
        r_state_n = r_state;
        r_accept  = 1'b0;
        ar_hs     = 1'b0;
        rd_hs     = 1'b0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        unique case (r_state)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    r_accept  = 1'b1;
                    r_state_n = ar_dec_unmapped ? R_OUT : R_FWD;
                end
            end
            R_FWD: begin
                m_arvalid = r_oh;
                ar_hs     = |(m_arready & r_oh);
                if (ar_hs) r_state_n = R_RESP;
            end
            R_RESP: begin
                m_rready = r_oh;
                rd_hs    = |(m_rvalid & r_oh);
                if (rd_hs) r_state_n = R_OUT;
            end
            R_OUT: begin
                s_rvalid = 1'b1;
                if (s_rready) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            ar_addr <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_resp  <= OKAY;
        end else begin
            r_state <= r_state_n;
            if (r_accept) begin
                ar_addr <= s_araddr;
                r_sel   <= ar_dec_sel;
                if (ar_dec_unmapped) begin
                    r_data <= '0;
                    r_resp <= DECERR;
                end
            end
            if (rd_hs) begin
                r_data <= m_rdata_sel;
                r_resp <= m_rresp_sel;
            end
        end
    end

    // Write and read DECERRs in the same cycle both count.
    assign err_inc = {1'b0, w_accept & aw_dec_unmapped} + {1'b0, r_accept & ar_dec_unmapped};
    assign err_sum = {1'b0, err_count} + 17'(err_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_inc != 2'd0) begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: tb/tb_axi4_lite_xbar_1xn.sv
// Directed bench for axi4_lite_xbar_1xn with two behavioural slaves (configurable wait states).
module tb_axi4_lite_xbar_1xn;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [63:0] m_awaddr, m_wdata, m_araddr;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [1:0]  m_awready = '0, m_wready = '0, m_bvalid = '0, m_arready = '0, m_rvalid = '0;
    logic [3:0]  m_bresp = '0, m_rresp = '0;
    logic [63:0] m_rdata = '0;
    logic [15:0] err_count;

    axi4_lite_xbar_1xn dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_araddr(m_araddr),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_rready(m_rready),
        .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
        .m_arready(m_arready), .m_rvalid(m_rvalid),
        .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model configuration and observation state.
    int          aw_delay [2] = '{0, 0};
    int          w_delay  [2] = '{0, 0};
    int          b_delay  [2] = '{0, 0};
    logic [1:0]  b_resp_cfg [2] = '{2'b00, 2'b00};
    int          aw_cnt [2] = '{0, 0};
    int          w_cnt  [2] = '{0, 0};
    int          b_cnt  [2] = '{0, 0};
    int          aw_hs  [2] = '{0, 0};
    int          b_hs   [2] = '{0, 0};
    logic        aw_got [2], w_got [2], b_pend [2], r_pend [2];
    logic [31:0] last_awaddr [2], last_wdata [2], rd_val [2];
    logic [3:0]  last_wstrb [2];
    logic [31:0] mem [2][64];
    int          awv_cyc = 0, wv_cyc = 0, any_valid_cyc = 0;
    logic [1:0]  aw_now, w_now;
    logic [31:0] wa [2], wd [2];

    assign aw_now = m_awvalid & m_awready;
    assign w_now  = m_wvalid & m_wready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wa[i] = aw_now[i] ? m_awaddr[i*32 +: 32] : last_awaddr[i];
            wd[i] = w_now[i] ? m_wdata[i*32 +: 32] : last_wdata[i];
        end
    end

    // Slaves record handshakes on the active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                aw_got[i] <= 1'b0;
                w_got[i]  <= 1'b0;
                b_pend[i] <= 1'b0;
                r_pend[i] <= 1'b0;
                for (int j = 0; j < 64; j++) mem[i][j] <= {8'(i), 8'(j), 16'h5A5A};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (aw_now[i]) begin
                    last_awaddr[i] <= m_awaddr[i*32 +: 32];
                    aw_hs[i]       <= aw_hs[i] + 1;
                end
                if (w_now[i]) begin
                    last_wdata[i] <= m_wdata[i*32 +: 32];
                    last_wstrb[i] <= m_wstrb[i*4 +: 4];
                end
                if ((aw_got[i] || aw_now[i]) && (w_got[i] || w_now[i])) begin
                    mem[i][wa[i][7:2]] <= wd[i];
                    b_pend[i] <= 1'b1;
                    aw_got[i] <= 1'b0;
                    w_got[i]  <= 1'b0;
                end else begin
                    aw_got[i] <= aw_got[i] || aw_now[i];
                    w_got[i]  <= w_got[i] || w_now[i];
                end
                if (m_bvalid[i] && m_bready[i]) begin
                    b_pend[i] <= 1'b0;
                    b_hs[i]   <= b_hs[i] + 1;
                end
                if (m_arvalid[i] && m_arready[i]) begin
                    r_pend[i] <= 1'b1;
                    rd_val[i] <= mem[i][m_araddr[i*32+2 +: 6]];
                end
                if (m_rvalid[i] && m_rready[i]) r_pend[i] <= 1'b0;
            end
        end
    end

    // Slaves drive their responses on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_awready[i] = 1'b0; m_wready[i] = 1'b0; m_bvalid[i] = 1'b0;
                m_arready[i] = 1'b0; m_rvalid[i] = 1'b0;
                aw_cnt[i] = 0; w_cnt[i] = 0; b_cnt[i] = 0;
            end else begin
                if (m_awvalid[i]) begin
                    if (aw_cnt[i] >= aw_delay[i]) m_awready[i] = 1'b1;
                    else aw_cnt[i]++;
                end else begin
                    m_awready[i] = 1'b0; aw_cnt[i] = 0;
                end
                if (m_wvalid[i]) begin
                    if (w_cnt[i] >= w_delay[i]) m_wready[i] = 1'b1;
                    else w_cnt[i]++;
                end else begin
                    m_wready[i] = 1'b0; w_cnt[i] = 0;
                end
                if (b_pend[i]) begin
                    if (b_cnt[i] >= b_delay[i]) begin
                        m_bvalid[i] = 1'b1;
                        m_bresp[i*2 +: 2] = b_resp_cfg[i];
                    end else b_cnt[i]++;
                end else begin
                    m_bvalid[i] = 1'b0; b_cnt[i] = 0;
                end
                m_arready[i] = m_arvalid[i];
                m_rvalid[i]  = r_pend[i];
                m_rdata[i*32 +: 32] = rd_val[i];
                m_rresp[i*2 +: 2] = 2'b00;
            end
        end
        if (m_awvalid[0]) awv_cyc++;
        if (m_wvalid[0]) wv_cyc++;
        if (|{m_awvalid, m_wvalid, m_arvalid}) any_valid_cyc++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Returns latency: response handshake edge minus accept edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold,
                            output int lat, output logic [1:0] resp);
        int n, t;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        t = 0;
        while (!s_awready && t < 100) begin @(negedge clk); #1; t++; end
        chk("aw_accept_timeout", 32'(t >= 100), 32'd0);
        @(posedge clk); #1;
        n = cyc;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!s_bvalid && t < 100) begin @(negedge clk); t++; end
        chk("b_wait_timeout", 32'(t >= 100), 32'd0);
        lat  = cyc - n + 1;
        resp = s_bresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("b_hold_valid", 32'(s_bvalid), 32'd1);
            chk("b_hold_resp", 32'(s_bresp), 32'(resp));
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] data,
                           output logic [1:0] resp);
        int n, t;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        #1;
        t = 0;
        while (!s_arready && t < 100) begin @(negedge clk); #1; t++; end
        chk("ar_accept_timeout", 32'(t >= 100), 32'd0);
        @(posedge clk); #1;
        n = cyc;
        s_arvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!s_rvalid && t < 100) begin @(negedge clk); t++; end
        chk("r_wait_timeout", 32'(t >= 100), 32'd0);
        lat  = cyc - n + 1;
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wl, rl, t, snap_aw, snap_w, snap_b, snap_any;
        logic [1:0]  wr, rr;
        logic [31:0] rd;

        rst = 1'b1;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valids", 32'({s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
        chk("reset_resp_rdata", {s_rdata[29:0], s_bresp} | 32'(s_rresp), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write to slave 0.
        do_write(32'h0000_0004, 32'hAABB_CCDD, 0, wl, wr);
        chk("w0_bresp", 32'(wr), 32'd0);
        chk("w0_latency", 32'(wl), 32'd3);
        chk("w0_awaddr", last_awaddr[0], 32'h0000_0004);
        chk("w0_wdata", last_wdata[0], 32'hAABB_CCDD);
        chk("w0_wstrb", 32'(last_wstrb[0]), 32'hF);
        chk("w0_slave1_untouched", 32'(aw_hs[1]), 32'd0);

        // Write then read back on slave 1.
        do_write(32'h0000_0104, 32'hDDCB_BBAA, 0, wl, wr);
        chk("w1_bresp", 32'(wr), 32'd0);
        chk("w1_awaddr", last_awaddr[1], 32'h0000_0104);
        do_read(32'h0000_0104, rl, rd, rr);
        chk("r1_rdata", rd, 32'hDDCB_BBAA);
        chk("r1_rresp", 32'(rr), 32'd0);
        chk("r1_latency", 32'(rl), 32'd3);

        // Unmapped write and read.
        snap_any = any_valid_cyc;
        do_write(32'h0000_0300, 32'h1234_5678, 0, wl, wr);
        chk("wu_bresp", 32'(wr), 32'd3);
        chk("wu_latency", 32'(wl), 32'd1);
        do_read(32'h0000_0300, rl, rd, rr);
        chk("ru_rdata", rd, 32'd0);
        chk("ru_rresp", 32'(rr), 32'd3);
        chk("ru_latency", 32'(rl), 32'd1);
        chk("unmapped_no_valids", 32'(any_valid_cyc - snap_any), 32'd0);
        chk("err_count_2", 32'(err_count), 32'd2);

        // Simultaneous write and read DECERR add two.
        fork
            do_write(32'h0000_0200, 32'h0, 0, wl, wr);
            do_read(32'h0000_1000, rl, rd, rr);
        join
        chk("dual_unmapped_bresp", 32'(wr), 32'd3);
        chk("dual_unmapped_rresp", 32'(rr), 32'd3);
        chk("err_count_4", 32'(err_count), 32'd4);

        // Concurrent write to slave 0 and read from slave 1.
        fork
            do_write(32'h0000_0008, 32'hDEAD_BEEF, 0, wl, wr);
            do_read(32'h0000_0108, rl, rd, rr);
        join
        chk("conc_bresp", 32'(wr), 32'd0);
        chk("conc_w_latency", 32'(wl), 32'd3);
        chk("conc_rdata", rd, 32'h0102_5A5A);
        chk("conc_r_latency", 32'(rl), 32'd3);
        do_read(32'h0000_0008, rl, rd, rr);
        chk("conc_readback", rd, 32'hDEAD_BEEF);

        // Slave 0 stalls awready 3 cycles and wready 1 cycle.
        aw_delay[0] = 3; w_delay[0] = 1;
        snap_aw = awv_cyc; snap_w = wv_cyc; snap_b = b_hs[0];
        do_write(32'h0000_000C, 32'h1122_3344, 0, wl, wr);
        aw_delay[0] = 0; w_delay[0] = 0;
        chk("stall_bresp", 32'(wr), 32'd0);
        chk("stall_latency", 32'(wl), 32'd6);
        chk("stall_awvalid_cycles", 32'(awv_cyc - snap_aw), 32'd4);
        chk("stall_wvalid_cycles", 32'(wv_cyc - snap_w), 32'd2);
        chk("stall_single_b", 32'(b_hs[0] - snap_b), 32'd1);

        // SLVERR pass-through with upstream bready held off for 5 cycles.
        b_resp_cfg[1] = 2'b10;
        do_write(32'h0000_0110, 32'h0F0F_0F0F, 5, wl, wr);
        b_resp_cfg[1] = 2'b00;
        chk("slverr_bresp", 32'(wr), 32'd2);
        chk("slverr_no_err_count", 32'(err_count), 32'd4);

        // Reset while the write path waits in W_RESP.
        b_delay[0] = 20;
        @(negedge clk);
        s_awaddr = 32'h0000_0010; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        chk("rst_pre_accept", 32'(s_awready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!m_bready[0] && t < 50) begin @(negedge clk); t++; end
        chk("rst_reach_wresp", 32'(m_bready[0]), 32'd1);
        snap_b = b_hs[0];
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", 32'({s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
        chk("rst_mid_bresp", 32'(s_bresp), 32'd0);
        chk("rst_mid_rdata", s_rdata, 32'd0);
        chk("rst_mid_err_count", 32'(err_count), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b_delay[0] = 0;
        repeat (3) @(negedge clk);
        chk("rst_no_b_handshake", 32'(b_hs[0]), 32'(snap_b));

        do_write(32'h0000_0014, 32'h5555_AAAA, 0, wl, wr);
        chk("recover_bresp", 32'(wr), 32'd0);
        chk("recover_latency", 32'(wl), 32'd3);
        chk("recover_awaddr", last_awaddr[0], 32'h0000_0014);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
